// File: rtl/reg_shift_seq.sv
// reg_shift_seq: multi-cycle ARM A32 register-specified shifter.
// Accepts a shift request in IDLE, walks through the effective count STEP
// bit positions per cycle, and presents the result plus shifter carry-out
// on a one-cycle done pulse. Outputs hold until the next done.
module reg_shift_seq #(
  parameter int STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] data_in,
  input  logic [7:0]  amount,
  input  logic [1:0]  sh_type,
  input  logic        carry_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic        carry_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [1:0] T_LSL = 2'b00;
  localparam logic [1:0] T_LSR = 2'b01;
  localparam logic [1:0] T_ASR = 2'b10;

  localparam logic [5:0] STEP_W = 6'(STEP);

  logic [1:0]  state;
  logic [31:0] work;
  logic        work_c;
  logic [1:0]  op;
  logic [5:0]  rem;

  logic [5:0]  eff;
  logic [5:0]  k;
  logic [31:0] step_w;
  logic        step_c;

  // Clamp the raw amount so that plain bit-serial shifting yields the ARM
  // corner cases (e.g. LSL 33 shifts the last 1 out and leaves C=0).
  always_comb begin
    eff = 6'd0;
    case (sh_type)
      T_LSL, T_LSR: eff = (amount > 8'd33) ? 6'd33 : amount[5:0];
      T_ASR:        eff = (amount > 8'd32) ? 6'd32 : amount[5:0];
      default: begin
        if (amount == 8'd0)
          eff = 6'd0;
        else if (amount[4:0] == 5'd0)
          eff = 6'd32;
        else
          eff = {1'b0, amount[4:0]};
      end
    endcase
  end

  // Positions handled this cycle: whatever is left, capped at STEP.
  always_comb begin
    k = (rem < STEP_W) ? rem : STEP_W;
  end

  // Unrolled chain of single-bit shifts; only the first k stages are active.
  always_comb begin
    step_w = work;
    step_c = work_c;
    for (int i = 0; i < STEP; i++) begin
      if (6'(i) < k) begin
        case (op)
          T_LSL: begin
            step_c = step_w[31];
            step_w = {step_w[30:0], 1'b0};
          end
          T_LSR: begin
            step_c = step_w[0];
            step_w = {1'b0, step_w[31:1]};
          end
          T_ASR: begin
            step_c = step_w[0];
            step_w = {step_w[31], step_w[31:1]};
          end
          default: begin
            step_c = step_w[0];
            step_w = {step_w[0], step_w[31:1]};
          end
        endcase
      end
    end
  end

  // Control FSM, working registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      work      <= 32'd0;
      work_c    <= 1'b0;
      op        <= 2'b00;
      rem       <= 6'd0;
      data_out  <= 32'd0;
      carry_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            work   <= data_in;
            work_c <= carry_in;
            op     <= sh_type;
            rem    <= eff;
            if (eff == 6'd0) begin
              data_out  <= data_in;
              carry_out <= carry_in;
              state     <= DONE;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work   <= step_w;
          work_c <= step_c;
          rem    <= rem - k;
          if (rem == k) begin
            data_out  <= step_w;
            carry_out <= step_c;
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_reg_shift_seq.sv
// tb_reg_shift_seq: directed self-checking bench for reg_shift_seq (STEP=8).
module tb_reg_shift_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] data_in;
  logic [7:0]  amount;
  logic [1:0]  sh_type;
  logic        carry_in;
  logic        busy;
  logic        done;
  logic [31:0] data_out;
  logic        carry_out;

  int errors;
  int checks;

  reg_shift_seq #(.STEP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .amount    (amount),
    .sh_type   (sh_type),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .data_out  (data_out),
    .carry_out (carry_out)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request from an IDLE cycle (called #1 after a rising edge),
  // measure cycles from the accepting edge to done, then step into IDLE.
  task automatic applyStimulus(input logic [31:0] d, input logic [7:0] a,
                               input logic [1:0] t, input logic ci,
                               output int lat);
    data_in  = d;
    amount   = a;
    sh_type  = t;
    carry_in = ci;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout: done never rose (amount=%0d type=%0d)", a, t);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; start = 1'b0; data_in = 32'd0; amount = 8'd0; sh_type = 2'b00; carry_in = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    checks++; if (data_out !== 32'd0) begin errors++; $display("[TB] FAIL reset_data: got %h want 0", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_carry: got %b want 0", carry_out); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    // Leave non-zero outputs behind so the mid-shift reset visibly clears them.
    applyStimulus(32'h8000_0001, 8'd1, 2'b00, 1'b0, lat);
    checks++; if (data_out !== 32'h0000_0002) begin errors++; $display("[TB] FAIL pre_reset_data: got %h want 00000002", data_out); end
    // Start LSL #20 and reset while it is shifting.
    data_in = 32'h8000_0001; amount = 8'd20; sh_type = 2'b00; carry_in = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #4;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done: got %b want 0", done); end
    checks++; if (data_out !== 32'd0) begin errors++; $display("[TB] FAIL midreset_data: got %h want 0", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL midreset_carry: got %b want 0", carry_out); end
    #2; rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lsl();
    int lat;
    applyStimulus(32'h8000_0001, 8'd1, 2'b00, 1'b0, lat);
    checks++; if (data_out !== 32'h0000_0002) begin errors++; $display("[TB] FAIL lsl1_data: got %h want 00000002", data_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("[TB] FAIL lsl1_carry: got %b want 1", carry_out); end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL lsl1_latency: got %0d want 2", lat); end
    applyStimulus(32'h8000_0001, 8'd32, 2'b00, 1'b0, lat);
    checks++; if (data_out !== 32'd0) begin errors++; $display("[TB] FAIL lsl32_data: got %h want 0", data_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("[TB] FAIL lsl32_carry: got %b want 1", carry_out); end
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL lsl32_latency: got %0d want 5", lat); end
    applyStimulus(32'h8000_0001, 8'd33, 2'b00, 1'b1, lat);
    checks++; if (data_out !== 32'd0) begin errors++; $display("[TB] FAIL lsl33_data: got %h want 0", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL lsl33_carry: got %b want 0", carry_out); end
    checks++; if (lat != 6) begin errors++; $display("[TB] FAIL lsl33_latency: got %0d want 6", lat); end
  endtask

  task automatic test_lsr();
    int lat;
    applyStimulus(32'h8000_0001, 8'd0, 2'b01, 1'b1, lat);
    checks++; if (data_out !== 32'h8000_0001) begin errors++; $display("[TB] FAIL lsr0_data: got %h want 80000001", data_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("[TB] FAIL lsr0_carry: got %b want 1", carry_out); end
    checks++; if (lat != 1) begin errors++; $display("[TB] FAIL lsr0_latency: got %0d want 1", lat); end
    applyStimulus(32'h8000_0001, 8'd32, 2'b01, 1'b0, lat);
    checks++; if (data_out !== 32'd0) begin errors++; $display("[TB] FAIL lsr32_data: got %h want 0", data_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("[TB] FAIL lsr32_carry: got %b want 1", carry_out); end
    applyStimulus(32'h8000_0001, 8'd200, 2'b01, 1'b1, lat);
    checks++; if (data_out !== 32'd0) begin errors++; $display("[TB] FAIL lsr200_data: got %h want 0", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL lsr200_carry: got %b want 0", carry_out); end
    checks++; if (lat != 6) begin errors++; $display("[TB] FAIL lsr200_latency: got %0d want 6", lat); end
  endtask

  task automatic test_asr();
    int lat;
    applyStimulus(32'h8000_0000, 8'd4, 2'b10, 1'b1, lat);
    checks++; if (data_out !== 32'hF800_0000) begin errors++; $display("[TB] FAIL asr4_data: got %h want f8000000", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL asr4_carry: got %b want 0", carry_out); end
    applyStimulus(32'h8000_0000, 8'd255, 2'b10, 1'b0, lat);
    checks++; if (data_out !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL asr255_data: got %h want ffffffff", data_out); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("[TB] FAIL asr255_carry: got %b want 1", carry_out); end
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL asr255_latency: got %0d want 5", lat); end
    applyStimulus(32'h7FFF_FFFF, 8'd40, 2'b10, 1'b1, lat);
    checks++; if (data_out !== 32'd0) begin errors++; $display("[TB] FAIL asr40_data: got %h want 0", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL asr40_carry: got %b want 0", carry_out); end
  endtask

  task automatic test_ror();
    int lat;
    applyStimulus(32'h0000_00F1, 8'd4, 2'b11, 1'b1, lat);
    checks++; if (data_out !== 32'h1000_000F) begin errors++; $display("[TB] FAIL ror4_data: got %h want 1000000f", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL ror4_carry: got %b want 0", carry_out); end
    applyStimulus(32'h0000_00F1, 8'd64, 2'b11, 1'b1, lat);
    checks++; if (data_out !== 32'h0000_00F1) begin errors++; $display("[TB] FAIL ror64_data: got %h want 000000f1", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL ror64_carry: got %b want 0", carry_out); end
    checks++; if (lat != 5) begin errors++; $display("[TB] FAIL ror64_latency: got %0d want 5", lat); end
    applyStimulus(32'h0000_00F1, 8'd36, 2'b11, 1'b1, lat);
    checks++; if (data_out !== 32'h1000_000F) begin errors++; $display("[TB] FAIL ror36_data: got %h want 1000000f", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL ror36_carry: got %b want 0", carry_out); end
    checks++; if (lat != 2) begin errors++; $display("[TB] FAIL ror36_latency: got %0d want 2", lat); end
  endtask

  task automatic test_back_to_back();
    int ndone;
    int lat;
    logic exp_done;
    logic exp_busy;
    // start held high: LSR #8 takes accept + 1 SHIFT + DONE + IDLE, so a
    // new op every 3 cycles with done on cycles 2,5,8.
    data_in = 32'hFF00_0000; amount = 8'd8; sh_type = 2'b01; carry_in = 1'b1; start = 1'b1;
    ndone = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(posedge clk); #1;
      exp_done = ((cyc % 3) == 2);
      exp_busy = ((cyc % 3) != 0);
      if (done) ndone++;
      checks++; if (done !== exp_done) begin errors++; $display("[TB] FAIL held_done c%0d: got %b want %b", cyc, done, exp_done); end
      checks++; if (busy !== exp_busy) begin errors++; $display("[TB] FAIL held_busy c%0d: got %b want %b", cyc, busy, exp_busy); end
      if (exp_done) begin
        checks++; if (data_out !== 32'h00FF_0000) begin errors++; $display("[TB] FAIL held_data c%0d: got %h want 00ff0000", cyc, data_out); end
      end
    end
    start = 1'b0;
    checks++; if (ndone != 3) begin errors++; $display("[TB] FAIL held_count: got %0d want 3", ndone); end
    // Now in IDLE. LSL #20 with a start pulse while busy that must be ignored.
    data_in = 32'h8000_0001; amount = 8'd20; sh_type = 2'b00; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    data_in = 32'h1234_5678; amount = 8'd0; sh_type = 2'b11; carry_in = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    lat = 3;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat != 4) begin errors++; $display("[TB] FAIL pulse_latency: got %0d want 4", lat); end
    checks++; if (data_out !== 32'h0010_0000) begin errors++; $display("[TB] FAIL pulse_data: got %h want 00100000", data_out); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("[TB] FAIL pulse_carry: got %b want 0", carry_out); end
    ndone = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("[TB] FAIL pulse_extra_op: got %0d active cycles want 0", ndone); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_lsl();
    test_lsr();
    test_asr();
    test_ror();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
